// File: rtl/toggle_sync_tx.sv
// toggle_sync_tx: source-side launcher for a toggle-handshake clock-domain crossing.
// Accepts one word through valid/ready and holds it in xfer_data. It flips req_tgl
// and waits until the synchronized acknowledge toggle matches req_tgl. Only then is
// the next word accepted.
// Optional feature: define TOGGLE_SYNC_TIMEOUT_EN to add an ack-overdue watchdog that
// drives the sticky timeout_err flag. Without it, timeout_err is tied to 0.
//
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready are
// both 1. in_ready is registered and does not depend on in_valid. in_valid/in_data
// are ignored while in_ready is 0. The upstream may change or drop in_valid freely.
module toggle_sync_tx #(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req_tgl,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             ack_tgl_sync,
    output logic             busy,
    output logic             done_pulse,
    output logic             timeout_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_pulse_q, done_pulse_d;
    logic             req_tgl_q, req_tgl_d;
    logic [WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic             accept;
    logic             complete;

    // The ack is compared only in WAIT, so a stray ack flip in INIT or IDLE has no effect.
    assign accept   = (state_q == ST_IDLE) && in_valid && in_ready_q;
    assign complete = (state_q == ST_WAIT) && (ack_tgl_sync == req_tgl_q);

    // Next-state and next-output logic. Every output is registered from these values.
    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        done_pulse_d = 1'b0;
        req_tgl_d    = req_tgl_q;
        xfer_data_d  = xfer_data_q;
        case (state_q)
            ST_INIT: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_WAIT;
                    in_ready_d  = 1'b0;
                    busy_d      = 1'b1;
                    req_tgl_d   = ~req_tgl_q;
                    xfer_data_d = in_data;
                end
            end
            ST_WAIT: begin
                if (complete) begin
                    state_d      = ST_IDLE;
                    in_ready_d   = 1'b1;
                    busy_d       = 1'b0;
                    done_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_INIT;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // FSM state and registered handshake outputs. Async reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_pulse_q <= 1'b0;
            req_tgl_q    <= 1'b0;
            xfer_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_pulse_q <= done_pulse_d;
            req_tgl_q    <= req_tgl_d;
            xfer_data_q  <= xfer_data_d;
        end
    end

`ifdef TOGGLE_SYNC_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    // Watchdog: count WAIT cycles, saturating. Flag once the limit is reached and keep the flag until reset.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        if (accept) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            if (wait_cnt_q != 16'hFFFF) begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
            if (!complete && (wait_cnt_d >= TIMEOUT_LIMIT)) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout_limit;
    assign unused_timeout_limit = ^TIMEOUT_LIMIT;
    assign timeout_err          = 1'b0;
`endif

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done_pulse = done_pulse_q;
    assign req_tgl    = req_tgl_q;
    assign xfer_data  = xfer_data_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_toggle_sync_tx.sv
// Directed testbench for toggle_sync_tx. Inputs change 1 time unit after a rising
// edge. Outputs are sampled at that same point, before the inputs change.
module tb_toggle_sync_tx;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         req_tgl;
  logic [W-1:0] xfer_data;
  logic         ack_tgl_sync;
  logic         busy;
  logic         done_pulse;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  int n_checks;
  int n_fail;
  logic exp_to;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  toggle_sync_tx #(.WIDTH(W), .TIMEOUT_CYCLES(10)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .req_tgl      (req_tgl),
    .xfer_data    (xfer_data),
    .ack_tgl_sync (ack_tgl_sync),
    .busy         (busy),
    .done_pulse   (done_pulse),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, " req_tgl"}, 32'(req_tgl), 32'd0);
    check_eq({tag, " xfer_data"}, 32'(xfer_data), 32'd0);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " done_pulse"}, 32'(done_pulse), 32'd0);
    check_eq({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // driver: present a word for one edge, then withdraw it
  task automatic send_word(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    ack_tgl_sync = 1'b0;

    // 1. reset then release
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    check_eq("init in_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("idle in_ready", 32'(in_ready), 32'd1);
    check_eq("idle busy", 32'(busy), 32'd0);

    // 2. single transfer of 0xA5
    send_word(8'hA5);
    check_eq("t2 xfer_data", 32'(xfer_data), 32'hA5);
    check_eq("t2 req_tgl", 32'(req_tgl), 32'd1);
    check_eq("t2 busy", 32'(busy), 32'd1);
    check_eq("t2 in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t2 wait busy", 32'(busy), 32'd1);
      check_eq("t2 wait done", 32'(done_pulse), 32'd0);
    end
    ack_tgl_sync = 1'b1;
    tick();
    check_eq("t2 done", 32'(done_pulse), 32'd1);
    check_eq("t2 in_ready", 32'(in_ready), 32'd1);
    check_eq("t2 busy low", 32'(busy), 32'd0);
    tick();
    check_eq("t2 done one cycle", 32'(done_pulse), 32'd0);

    // 3. back-to-back 0x11 then 0x22 (in_valid held high across both)
    in_valid = 1'b1;
    in_data  = 8'h11;
    tick();
    check_eq("t3 req after 11", 32'(req_tgl), 32'd0);
    check_eq("t3 xfer 11", 32'(xfer_data), 32'h11);
    ack_tgl_sync = 1'b0;
    in_data      = 8'h22;
    tick();
    check_eq("t3 done 1", 32'(done_pulse), 32'd1);
    check_eq("t3 xfer still 11", 32'(xfer_data), 32'h11);
    check_eq("t3 ready", 32'(in_ready), 32'd1);
    tick();
    check_eq("t3 req after 22", 32'(req_tgl), 32'd1);
    check_eq("t3 xfer 22", 32'(xfer_data), 32'h22);
    check_eq("t3 busy", 32'(busy), 32'd1);
    check_eq("t3 done gap", 32'(done_pulse), 32'd0);
    in_valid     = 1'b0;
    ack_tgl_sync = 1'b1;
    tick();
    check_eq("t3 done 2", 32'(done_pulse), 32'd1);
    tick();
    check_eq("t3 done 2 end", 32'(done_pulse), 32'd0);

    // 4. stall: in_valid with 0xFF during WAIT is ignored
    send_word(8'h5A);
    check_eq("t4 req", 32'(req_tgl), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    tick();
    check_eq("t4 xfer held", 32'(xfer_data), 32'h5A);
    check_eq("t4 busy", 32'(busy), 32'd1);
    check_eq("t4 req held", 32'(req_tgl), 32'd0);
    in_valid     = 1'b0;
    ack_tgl_sync = 1'b0;
    tick();
    check_eq("t4 done", 32'(done_pulse), 32'd1);
    check_eq("t4 xfer after", 32'(xfer_data), 32'h5A);
    tick();
    // stray ack flip while idle
    ack_tgl_sync = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t4 stray done", 32'(done_pulse), 32'd0);
      check_eq("t4 stray busy", 32'(busy), 32'd0);
      check_eq("t4 stray ready", 32'(in_ready), 32'd1);
      check_eq("t4 stray state", 32'(state_dbg), 32'd1);
    end
    check_eq("t4 stray req", 32'(req_tgl), 32'd0);
    ack_tgl_sync = 1'b0;
    tick();

    // 5. reset mid-transfer, then a fresh transfer of 0x3C
    send_word(8'h77);
    check_eq("t5 req", 32'(req_tgl), 32'd1);
    tick();
    check_eq("t5 busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5 async reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t5 ready after release", 32'(in_ready), 32'd1);
    send_word(8'h3C);
    check_eq("t5 xfer 3C", 32'(xfer_data), 32'h3C);
    check_eq("t5 req 3C", 32'(req_tgl), 32'd1);
    ack_tgl_sync = 1'b1;
    tick();
    check_eq("t5 done", 32'(done_pulse), 32'd1);
    check_eq("t5 xfer kept", 32'(xfer_data), 32'h3C);
    tick();

    // 6. withheld ack: timeout_err only when the watchdog is built in
`ifdef TOGGLE_SYNC_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    send_word(8'h99);
    check_eq("t6 req", 32'(req_tgl), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_eq("t6 no timeout yet", 32'(timeout_err), 32'd0);
    end
    tick();
    check_eq("t6 timeout at 10", 32'(timeout_err), 32'(exp_to));
    check_eq("t6 still busy", 32'(busy), 32'd1);
    ack_tgl_sync = 1'b0;
    tick();
    check_eq("t6 done", 32'(done_pulse), 32'd1);
    check_eq("t6 timeout sticky", 32'(timeout_err), 32'(exp_to));
    tick();
    check_eq("t6 timeout sticky idle", 32'(timeout_err), 32'(exp_to));
    check_eq("t6 ready", 32'(in_ready), 32'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
